// File: rtl/sd_init_seq_pkg.sv
// sd_init_seq_pkg: command indices, check pattern, error codes and FSM/step encodings.
package sd_init_seq_pkg;
    localparam logic [5:0] CMD2  = 6'd2;
    localparam logic [5:0] CMD3  = 6'd3;
    localparam logic [5:0] CMD6  = 6'd6;
    localparam logic [5:0] CMD7  = 6'd7;
    localparam logic [5:0] CMD8  = 6'd8;
    localparam logic [5:0] CMD41 = 6'd41;
    localparam logic [5:0] CMD55 = 6'd55;
    localparam logic [11:0] CMD8_PATTERN = 12'h1AA;
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_ECHO    = 2'd2;
    localparam logic [1:0] ERR_RETRY   = 2'd3;
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_WAIT_ACK  = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_CHECK     = 3'd4;
    localparam logic [2:0] S_READY     = 3'd5;
    localparam logic [2:0] S_ERROR     = 3'd6;
    localparam logic [2:0] STEP_CMD8   = 3'd0;
    localparam logic [2:0] STEP_CMD55A = 3'd1;
    localparam logic [2:0] STEP_ACMD41 = 3'd2;
    localparam logic [2:0] STEP_CMD2   = 3'd3;
    localparam logic [2:0] STEP_CMD3   = 3'd4;
    localparam logic [2:0] STEP_CMD7   = 3'd5;
    localparam logic [2:0] STEP_CMD55B = 3'd6;
    localparam logic [2:0] STEP_ACMD6  = 3'd7;
    typedef struct packed {
        logic [5:0]  index;
        logic [31:0] arg;
    } cmd_t;
endpackage

// File: rtl/sd_init_seq_if.sv
// sd_init_seq_if: command/response handshake between the init sequencer and the CMD line driver.
interface sd_init_seq_if;
    logic        odrv_start;
    logic [5:0]  odrv_cmd_index;
    logic [31:0] odrv_cmd_arg;
    logic [31:0] idrv_resp;
    logic        idrv_done;
    logic        odrv_rst;
    modport master (
        output odrv_start, odrv_cmd_index, odrv_cmd_arg, odrv_rst,
        input  idrv_resp, idrv_done
    );
    modport slave (
        input  odrv_start, odrv_cmd_index, odrv_cmd_arg, odrv_rst,
        output idrv_resp, idrv_done
    );
endinterface

// File: rtl/sd_init_seq_cmd_table.sv
// sd_cmd_table: maps the current init step and card RCA to a command index/argument.
module sd_cmd_table
    import sd_init_seq_pkg::*;
#(
    parameter logic [31:0] ACMD41_ARG = 32'h40FF8000
) (
    input  logic [2:0]  step,
    input  logic [15:0] rca,
    output cmd_t        cmd
);
    always_comb begin
        cmd = '{index: CMD8, arg: 32'h0000_01AA};
        case (step)
            STEP_CMD55A: cmd = '{index: CMD55, arg: 32'h0};
            STEP_ACMD41: cmd = '{index: CMD41, arg: ACMD41_ARG};
            STEP_CMD2:   cmd = '{index: CMD2,  arg: 32'h0};
            STEP_CMD3:   cmd = '{index: CMD3,  arg: 32'h0};
            STEP_CMD7:   cmd = '{index: CMD7,  arg: {rca, 16'h0}};
            STEP_CMD55B: cmd = '{index: CMD55, arg: {rca, 16'h0}};
            STEP_ACMD6:  cmd = '{index: CMD6,  arg: 32'h2};
            default:     cmd = '{index: CMD8,  arg: 32'h0000_01AA};
        endcase
    end
endmodule

// File: rtl/sd_init_seq.sv
// sd_init_seq: SD identification/setup sequencer driving the CMD line driver one command at a time.
module sd_init_seq
    import sd_init_seq_pkg::*;
#(
    parameter int          ACMD41_RETRIES = 1000,
    parameter int          RESP_TIMEOUT   = 4096,
    parameter logic [31:0] ACMD41_ARG     = 32'h40FF8000,
    parameter bit          BUS_4BIT       = 1'b1
) (
    input  logic          iclk,
    input  logic          irst_n,
    input  logic          istart,
    sd_init_seq_if.master drv,
    output logic          ordy,
    output logic          oerr,
    output logic [1:0]    oerr_code,
    output logic [15:0]   orca,
    output logic          ofast_clk
);
    localparam int RW = $clog2(ACMD41_RETRIES + 1);
    localparam int TW = (RESP_TIMEOUT > 2) ? $clog2(RESP_TIMEOUT) : 1;

    logic [2:0]    state;
    logic [2:0]    step;
    logic [RW-1:0] retry;
    logic [RW-1:0] retry_nx;
    logic [TW-1:0] tcnt;
    logic          start_q;
    logic          rise;
    logic          wait_exit;
    logic          timeout;
    logic          drv_rst;
    logic          unused_resp;
    cmd_t          cmd;
    cmd_t          cmd_q;

    sd_cmd_table #(.ACMD41_ARG(ACMD41_ARG)) u_table (.step(step), .rca(orca), .cmd(cmd));

    assign rise      = istart & ~start_q;
    assign retry_nx  = retry + 1'b1;
    assign wait_exit = (state == S_WAIT_ACK) ? ~drv.idrv_done : drv.idrv_done;
    // Fires on the cycle the counter steps onto RESP_TIMEOUT-1, so odrv_rst lands in that cycle.
    assign timeout   = (state == S_WAIT_ACK || state == S_WAIT_DONE) && !wait_exit && tcnt == TW'(RESP_TIMEOUT - 2);
    assign ordy      = state == S_READY;
    assign oerr      = state == S_ERROR;
    assign unused_resp = ^drv.idrv_resp[15:12];

    assign drv.odrv_start     = state == S_ISSUE;
    assign drv.odrv_cmd_index = drv.odrv_start ? cmd.index : cmd_q.index;
    assign drv.odrv_cmd_arg   = drv.odrv_start ? cmd.arg : cmd_q.arg;
    assign drv.odrv_rst       = drv_rst;

    // start_q resets high so a level already present at reset release is not taken as an edge.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state     <= S_IDLE;
            step      <= STEP_CMD8;
            retry     <= '0;
            tcnt      <= '0;
            start_q   <= 1'b1;
            cmd_q     <= '0;
            drv_rst   <= 1'b0;
            oerr_code <= ERR_NONE;
            orca      <= '0;
            ofast_clk <= 1'b0;
        end else begin
            start_q <= istart;
            drv_rst <= 1'b0;
            case (state)
                S_IDLE, S_READY, S_ERROR: if (rise) begin
                    oerr_code <= ERR_NONE;
                    orca      <= '0;
                    ofast_clk <= 1'b0;
                    retry     <= '0;
                    step      <= STEP_CMD8;
                    state     <= S_ISSUE;
                end
                S_ISSUE: begin
                    cmd_q <= cmd;
                    tcnt  <= '0;
                    state <= S_WAIT_ACK;
                end
                S_WAIT_ACK, S_WAIT_DONE: begin
                    tcnt <= tcnt + 1'b1;
                    if (wait_exit) state <= (state == S_WAIT_ACK) ? S_WAIT_DONE : S_CHECK;
                    else if (timeout) begin
                        drv_rst   <= 1'b1;
                        oerr_code <= ERR_TIMEOUT;
                        state     <= S_ERROR;
                    end
                end
                S_CHECK: begin
                    state <= S_ISSUE;
                    case (step)
                        STEP_CMD8: if (drv.idrv_resp[11:0] == CMD8_PATTERN) step <= STEP_CMD55A;
                        else begin
                            oerr_code <= ERR_ECHO;
                            state     <= S_ERROR;
                        end
                        STEP_CMD55A: step <= STEP_ACMD41;
                        STEP_ACMD41: if (drv.idrv_resp[31]) step <= STEP_CMD2;
                        else begin
                            retry <= retry_nx;
                            if (retry_nx == RW'(ACMD41_RETRIES)) begin
                                oerr_code <= ERR_RETRY;
                                state     <= S_ERROR;
                            end else step <= STEP_CMD55A;
                        end
                        STEP_CMD2: step <= STEP_CMD3;
                        STEP_CMD3: begin
                            orca <= drv.idrv_resp[31:16];
                            step <= STEP_CMD7;
                        end
                        STEP_CMD7: begin
                            ofast_clk <= 1'b1;
                            if (BUS_4BIT) step <= STEP_CMD55B;
                            else state <= S_READY;
                        end
                        STEP_CMD55B: step <= STEP_ACMD6;
                        default: state <= S_READY;
                    endcase
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_init_seq.sv
// tb_sd_init_seq: scoreboard bench with a card/driver model for a 4-bit and a 1-bit configuration.
module tb_sd_init_seq;
    localparam int LAT = 48;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic a_start = 1'b0;
    logic b_start = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    logic [38:0] qa[$];
    logic [38:0] qb[$];

    logic        a_rdy, a_err, a_fast, b_rdy, b_err, b_fast;
    logic [1:0]  a_code, b_code;
    logic [15:0] a_rca, b_rca;

    int          a_acnt = 0, a_ok_at = 3, a_hang = 99, b_acnt = 0;
    logic [31:0] a_cmd8 = 32'h1AA;
    int          a_rst_cnt = 0, a_rst_at = 0, a_last_start = 0;
    logic [5:0]  a_last_idx = '0;

    logic [5:0]  h_idx [12] = '{6'd8, 6'd55, 6'd41, 6'd55, 6'd41, 6'd55, 6'd41, 6'd2, 6'd3, 6'd7, 6'd55, 6'd6};
    logic [31:0] h_arg [12] = '{32'h1AA, 32'h0, 32'h40FF8000, 32'h0, 32'h40FF8000, 32'h0, 32'h40FF8000,
                                32'h0, 32'h0, 32'hB3680000, 32'hB3680000, 32'h2};

    sd_init_seq_if a_if();
    sd_init_seq_if b_if();

    sd_init_seq #(.ACMD41_RETRIES(4), .RESP_TIMEOUT(64)) dut_a (
        .iclk(clk), .irst_n(rst_n), .istart(a_start), .drv(a_if),
        .ordy(a_rdy), .oerr(a_err), .oerr_code(a_code), .orca(a_rca), .ofast_clk(a_fast)
    );
    sd_init_seq #(.BUS_4BIT(1'b0)) dut_b (
        .iclk(clk), .irst_n(rst_n), .istart(b_start), .drv(b_if),
        .ordy(b_rdy), .oerr(b_err), .oerr_code(b_code), .orca(b_rca), .ofast_clk(b_fast)
    );

    function automatic logic [31:0] card_resp(input logic [5:0] idx, input logic [31:0] cmd8, input int acnt, input int ok_at);
        case (idx)
            6'd8:    return cmd8;
            6'd41:   return (ok_at != 0 && acnt == ok_at) ? 32'hC0FF8000 : 32'h00FF8000;
            6'd3:    return 32'hB3680500;
            default: return 32'h0000_0900;
        endcase
    endfunction

    function automatic logic [63:0] a_outs();
        return {3'b0, a_rdy, a_err, a_code, a_rca, a_fast, a_if.odrv_start, a_if.odrv_rst, a_if.odrv_cmd_index, a_if.odrv_cmd_arg};
    endfunction

    function automatic logic [63:0] b_outs();
        return {3'b0, b_rdy, b_err, b_code, b_rca, b_fast, b_if.odrv_start, b_if.odrv_rst, b_if.odrv_cmd_index, b_if.odrv_cmd_arg};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    task automatic push_one(input bit to_b, input bit fast, input logic [5:0] idx, input logic [31:0] arg);
        if (to_b) qb.push_back({fast, idx, arg});
        else qa.push_back({fast, idx, arg});
    endtask

    task automatic push_seq(input bit to_b, input int n);
        for (int i = 0; i < n; i++) push_one(to_b, i >= 10, h_idx[i], h_arg[i]);
    endtask

    task automatic go(input bit to_b);
        @(negedge clk);
        if (to_b) begin b_acnt = 0; b_start = 1'b1; end
        else begin a_acnt = 0; a_start = 1'b1; end
        repeat (2) @(negedge clk);
        a_start = 1'b0;
        b_start = 1'b0;
    endtask

    task automatic wait_end(input bit to_b, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (to_b ? (b_rdy | b_err) : (a_rdy | a_err)) return;
        end
        total++;
        bad++;
        $display("FAIL %s_wait: no ready/error within %0d cycles", to_b ? "b" : "a", budget);
    endtask

    // Driver/card model: drops done on start, answers after LAT cycles (or hangs on a_hang).
    initial begin
        logic [5:0] idx;
        a_if.idrv_done = 1'b1;
        a_if.idrv_resp = '0;
        forever begin
            @(negedge clk);
            if (a_if.odrv_start) begin
                idx = a_if.odrv_cmd_index;
                a_if.idrv_done = 1'b0;
                if (int'(idx) == a_hang) repeat (100) @(negedge clk);
                else begin
                    if (idx == 6'd41) a_acnt++;
                    repeat (LAT - 1) @(negedge clk);
                    a_if.idrv_resp = card_resp(idx, a_cmd8, a_acnt, a_ok_at);
                end
                a_if.idrv_done = 1'b1;
            end
        end
    end

    initial begin
        logic [5:0] idx;
        b_if.idrv_done = 1'b1;
        b_if.idrv_resp = '0;
        forever begin
            @(negedge clk);
            if (b_if.odrv_start) begin
                idx = b_if.odrv_cmd_index;
                b_if.idrv_done = 1'b0;
                if (idx == 6'd41) b_acnt++;
                repeat (LAT - 1) @(negedge clk);
                b_if.idrv_resp = card_resp(idx, 32'h1AA, b_acnt, 3);
                b_if.idrv_done = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (a_if.odrv_start) begin
            a_last_start = cyc;
            a_last_idx = a_if.odrv_cmd_index;
            if (qa.size() == 0) begin
                total++;
                bad++;
                $display("FAIL a_extra_start: got idx %0d want no command", a_if.odrv_cmd_index);
            end else check("a_cmd", 64'({a_fast, a_if.odrv_cmd_index, a_if.odrv_cmd_arg}), 64'(qa.pop_front()));
        end
        if (a_if.odrv_rst) begin
            a_rst_cnt++;
            a_rst_at = cyc;
        end
    end

    always @(negedge clk) begin
        if (b_if.odrv_start) begin
            if (qb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL b_extra_start: got idx %0d want no command", b_if.odrv_cmd_index);
            end else check("b_cmd", 64'({b_fast, b_if.odrv_cmd_index, b_if.odrv_cmd_arg}), 64'(qb.pop_front()));
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("a_reset", a_outs(), 64'h0);
        check("b_reset", b_outs(), 64'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        // Happy path, 4-bit bus
        push_seq(0, 12);
        go(0);
        wait_end(0, 3000);
        check("a_happy_status", 64'({a_rdy, a_err, a_code, a_rca, a_fast}), 64'({1'b1, 1'b0, 2'd0, 16'hB368, 1'b1}));
        check("a_happy_queue", 64'(qa.size()), 64'h0);
        // CMD8 echo mismatch
        a_cmd8 = 32'h1AB;
        push_one(0, 1'b0, 6'd8, 32'h1AA);
        go(0);
        wait_end(0, 1000);
        repeat (200) @(negedge clk);
        check("a_echo_status", 64'({a_rdy, a_err, a_code, a_rca, a_fast}), 64'({1'b0, 1'b1, 2'd2, 16'h0, 1'b0}));
        check("a_echo_queue", 64'(qa.size()), 64'h0);
        a_cmd8 = 32'h1AA;
        // ACMD41 never ready: exactly 4 attempts
        a_ok_at = 0;
        push_one(0, 1'b0, 6'd8, 32'h1AA);
        for (int k = 0; k < 4; k++) begin
            push_one(0, 1'b0, 6'd55, 32'h0);
            push_one(0, 1'b0, 6'd41, 32'h40FF8000);
        end
        go(0);
        wait_end(0, 3000);
        repeat (100) @(negedge clk);
        check("a_retry_status", 64'({a_rdy, a_err, a_code, a_rca, a_fast}), 64'({1'b0, 1'b1, 2'd3, 16'h0, 1'b0}));
        check("a_retry_queue", 64'(qa.size()), 64'h0);
        // Driver hangs on CMD2
        a_ok_at = 1;
        a_hang = 2;
        a_rst_cnt = 0;
        push_seq(0, 3);
        push_one(0, 1'b0, 6'd2, 32'h0);
        go(0);
        wait_end(0, 2000);
        repeat (150) @(negedge clk);
        check("a_timeout_rst_cycles", 64'(a_rst_cnt), 64'd1);
        check("a_timeout_rst_offset", 64'(a_rst_at - a_last_start), 64'd64);
        check("a_timeout_status", 64'({a_rdy, a_err, a_code, a_rca, a_fast}), 64'({1'b0, 1'b1, 2'd1, 16'h0, 1'b0}));
        check("a_timeout_queue", 64'(qa.size()), 64'h0);
        a_hang = 99;
        // Async reset during the ACMD41 wait
        a_ok_at = 3;
        a_last_idx = '0;
        push_seq(0, 3);
        go(0);
        for (int i = 0; i < 1000 && a_last_idx != 6'd41; i++) @(negedge clk);
        check("a_reached_acmd41", 64'(a_last_idx), 64'd41);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("a_async_reset", a_outs(), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT + 20) @(negedge clk);
        check("a_no_restart_without_edge", 64'(qa.size()), 64'h0);
        push_seq(0, 12);
        go(0);
        wait_end(0, 3000);
        check("a_after_reset_status", 64'({a_rdy, a_err, a_code, a_rca, a_fast}), 64'({1'b1, 1'b0, 2'd0, 16'hB368, 1'b1}));
        check("a_after_reset_queue", 64'(qa.size()), 64'h0);
        // 1-bit bus: stop after CMD7, then rerun from READY
        push_seq(1, 10);
        go(1);
        wait_end(1, 3000);
        check("b_status", 64'({b_rdy, b_err, b_code, b_rca, b_fast}), 64'({1'b1, 1'b0, 2'd0, 16'hB368, 1'b1}));
        check("b_queue", 64'(qb.size()), 64'h0);
        push_seq(1, 10);
        go(1);
        check("b_rerun_clear", 64'({b_rdy, b_rca, b_fast}), 64'h0);
        wait_end(1, 3000);
        repeat (100) @(negedge clk);
        check("b_rerun_status", 64'({b_rdy, b_err, b_code, b_rca, b_fast}), 64'({1'b1, 1'b0, 2'd0, 16'hB368, 1'b1}));
        check("b_rerun_queue", 64'(qb.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
